// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the data-memory responder and its storage array.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;
    localparam int LAT_W  = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: byte-lane write port, registered read port
// and an asynchronous debug read port.
module dmem_array
    import mips_mem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_idx,
    input  logic [WORD_W-1:0] wr_data,
    input  logic [BE_W-1:0]   wr_be,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_idx,
    output logic [WORD_W-1:0] rd_data,
    input  logic [AW-1:0]     dbg_idx,
    output logic [WORD_W-1:0] dbg_data
);

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BE_W; i++) begin
                if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) rd_data <= mem[rd_idx];
    end

    assign dbg_data = mem[dbg_idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding lw/sw responder: accepts a request in IDLE, waits LATENCY
// cycles, performs the access on the edge entering RESP and holds the result.
module dmem_responder
    import mips_mem_pkg::*;
#(
    parameter int MEM_DEPTH = 1024,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    input  logic [31:0]       dbg_addr,
    output logic [WORD_W-1:0] dbg_rdata
);

    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    dmem_state_t       state, state_next;
    logic [LAT_W-1:0]  cnt, cnt_next;
    logic              accept, do_access;

    logic              lat_we;
    logic [29:0]       lat_idx;
    logic [WORD_W-1:0] lat_wdata;
    logic [BE_W-1:0]   lat_be;

    logic              acc_we;
    logic [29:0]       acc_idx;
    logic [WORD_W-1:0] acc_wdata;
    logic [BE_W-1:0]   acc_be;
    logic              acc_ok;

    logic              err_q, load_q;
    logic [WORD_W-1:0] arr_rdata, arr_dbg;
    logic              dbg_ok;
    logic              unused_addr_bits;

    // With no wait cycles the access happens on the acceptance edge itself,
    // so it must use the live request rather than the latched copy.
    assign acc_we    = (LATENCY == 0) ? req_we          : lat_we;
    assign acc_idx   = (LATENCY == 0) ? req_addr[31:2]  : lat_idx;
    assign acc_wdata = (LATENCY == 0) ? req_wdata       : lat_wdata;
    assign acc_be    = (LATENCY == 0) ? req_be          : lat_be;
    assign acc_ok    = {2'b00, acc_idx} < 32'(MEM_DEPTH);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        do_access  = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = LAT_W'(LATENCY);
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - LAT_W'(1);
                if (cnt <= LAT_W'(1)) begin
                    do_access  = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            err_q  <= 1'b0;
            load_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                lat_we    <= req_we;
                lat_idx   <= req_addr[31:2];
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
            end
            if (do_access) begin
                err_q  <= !acc_ok;
                load_q <= acc_ok && !acc_we;
            end else if (state == RESP && resp_ready) begin
                err_q  <= 1'b0;
                load_q <= 1'b0;
            end
        end
    end

    // Reset on the access edge must abort the access, so the store never commits.
    dmem_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .AW        (AW)
    ) u_array (
        .clk      (clk),
        .wr_en    (do_access && acc_ok && acc_we && !reset),
        .wr_idx   (acc_idx[AW-1:0]),
        .wr_data  (acc_wdata),
        .wr_be    (acc_be),
        .rd_en    (do_access && acc_ok && !acc_we && !reset),
        .rd_idx   (acc_idx[AW-1:0]),
        .rd_data  (arr_rdata),
        .dbg_idx  (dbg_addr[AW+1:2]),
        .dbg_data (arr_dbg)
    );

    assign req_ready  = (state == IDLE) && !reset;
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign resp_rdata = (state == RESP && load_q) ? arr_rdata : '0;

    assign dbg_ok    = {2'b00, dbg_addr[31:2]} < 32'(MEM_DEPTH);
    assign dbg_rdata = dbg_ok ? arr_dbg : '0;

    assign unused_addr_bits = ^{req_addr[1:0], dbg_addr[1:0]};

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed table, hand-written corner
// sequences and randomized traffic against a word-array reference model.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata, dbg_addr, dbg_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [3:0]  z_req_be;
    logic        z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_resp_rdata, z_dbg_addr, z_dbg_rdata;

    int n_cmp, n_bad;

    logic [31:0] model [DEPTH];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    dmem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata)
    );

    dmem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (z_req_valid),
        .req_ready  (z_req_ready),
        .req_we     (z_req_we),
        .req_addr   (z_req_addr),
        .req_wdata  (z_req_wdata),
        .req_be     (z_req_be),
        .resp_valid (z_resp_valid),
        .resp_ready (z_resp_ready),
        .resp_rdata (z_resp_rdata),
        .resp_err   (z_resp_err),
        .dbg_addr   (z_dbg_addr),
        .dbg_rdata  (z_dbg_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: memory as a plain word array, access rules applied directly.
    function automatic void model_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                     input logic [3:0] be, output logic [31:0] rdata, output logic err);
        logic [31:0] idx;
        idx = addr >> 2;
        if (idx >= 32'(DEPTH)) begin
            err   = 1'b1;
            rdata = 32'h0;
        end else if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[idx[9:0]][8*i +: 8] = wdata[8*i +: 8];
            end
            err   = 1'b0;
            rdata = 32'h0;
        end else begin
            err   = 1'b0;
            rdata = model[idx[9:0]];
        end
    endfunction

    // One full transaction on the LATENCY=2 instance, starting and ending on a negedge.
    task automatic apply_stimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] be, input int hold,
                                  output logic [31:0] rdata, output logic err, output int lat);
        int          guard;
        logic [31:0] held;
        logic        held_err;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_output("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_be     = be;
        resp_ready = (hold == 0);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        rdata    = resp_rdata;
        err      = resp_err;
        held     = resp_rdata;
        held_err = resp_err;
        for (int h = 0; h < hold; h++) begin
            check_output("hold_valid", 32'(resp_valid), 32'd1);
            check_output("hold_rdata", resp_rdata, held);
            check_output("hold_err", 32'(resp_err), 32'(held_err));
            check_output("hold_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_output("post_valid", 32'(resp_valid), 32'd0);
        check_output("post_rdata", resp_rdata, 32'd0);
        check_output("post_err", 32'(resp_err), 32'd0);
        check_output("post_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic check_dbg(input string name, input logic [31:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        check_output(name, dbg_rdata, exp);
    endtask

    initial begin
        logic [31:0] rd, mrd;
        logic        er, mer;
        int          lat, guard;
        logic        we;
        logic [31:0] addr, wdata;
        logic [3:0]  be;
        logic [31:0] z_addr_seq [4];
        logic [31:0] z_data_seq [4];
        logic        z_we_seq [4];
        logic [31:0] z_exp_seq [4];
        int          acc_cyc [4];
        int          rsp_cyc [4];
        logic [31:0] rsp_data [4];
        logic        rsp_err [4];
        int          k, r;
        logic        accepted;

        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        resp_ready = 1'b0; dbg_addr = '0;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
        z_resp_ready = 1'b0; z_dbg_addr = '0;

        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 4'hF, 32'h0,         1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'h0000_00AA, 4'h1, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, 32'hDEAD_BEAA, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_1000, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[6]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1};
        vecs[7]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 32'h0,         1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0022, 32'h5566_0000, 4'hC, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 32'h5566_BEAA, 1'b0};
        vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0,         1'b1};
        vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0BAD_C0DE, 1'b0};

        repeat (3) @(negedge clk);
        check_output("rst_req_ready", 32'(req_ready), 32'd0);
        check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("rst_resp_rdata", resp_rdata, 32'd0);
        check_output("rst_resp_err", 32'(resp_err), 32'd0);
        reset = 1'b0;
        #1;
        check_output("rst_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Preload through stores, then reset: contents must survive reset.
        apply_stimulus(1'b1, 32'h10, 32'h0000_1234, 4'hF, 0, rd, er, lat);
        model_op(1'b1, 32'h10, 32'h0000_1234, 4'hF, mrd, mer);
        apply_stimulus(1'b1, 32'h30, 32'h1111_1111, 4'hF, 0, rd, er, lat);
        model_op(1'b1, 32'h30, 32'h1111_1111, 4'hF, mrd, mer);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
        check_output("preload_rdata", rd, 32'h0000_1234);
        check_output("preload_err", 32'(er), 32'd0);
        check_output("preload_latency", 32'(lat), 32'(LAT));

        $display("[TB] directed table");
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 0, rd, er, lat);
            model_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, mrd, mer);
            check_output($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check_output($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
        end
        check_dbg("dbg_after_oob_0x20", 32'h20, 32'h5566_BEAA);
        check_dbg("dbg_after_oob_0x0", 32'h0, 32'h0BAD_C0DE);
        check_dbg("dbg_after_oob_0x10", 32'h10, 32'h0000_1234);
        check_dbg("dbg_oob_zero", 32'h1000, 32'h0);

        $display("[TB] response held under backpressure");
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat);
        check_output("hold5_rdata", rd, 32'h0000_1234);
        check_output("hold5_latency", 32'(lat), 32'(LAT));

        $display("[TB] reset during WAIT");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hDEAD_DEAD; req_be = 4'hF;
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_output("wait_rst_resp_valid", 32'(resp_valid), 32'd0);
        check_output("wait_rst_req_ready", 32'(req_ready), 32'd1);
        check_dbg("wait_rst_no_commit", 32'h30, 32'h1111_1111);
        resp_ready = 1'b0;

        $display("[TB] reset during RESP");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h34; req_wdata = 32'hCAFE_F00D; req_be = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        guard = 0;
        while (resp_valid !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check_output("resp_rst_reached_resp", 32'(resp_valid), 32'd1);
        model_op(1'b1, 32'h34, 32'hCAFE_F00D, 4'hF, mrd, mer);
        reset = 1'b1;
        @(negedge clk);
        check_output("resp_rst_valid_drop", 32'(resp_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_output("resp_rst_req_ready", 32'(req_ready), 32'd1);
        check_dbg("resp_rst_committed", 32'h34, 32'hCAFE_F00D);

        $display("[TB] randomized traffic");
        for (int w = 64; w < 128; w++) begin
            wdata = $urandom();
            addr  = 32'(w * 4);
            apply_stimulus(1'b1, addr, wdata, 4'hF, 0, rd, er, lat);
            model_op(1'b1, addr, wdata, 4'hF, mrd, mer);
        end
        for (int n = 0; n < 150; n++) begin
            we    = 1'($urandom_range(1, 0));
            wdata = $urandom();
            be    = 4'($urandom_range(15, 0));
            if ($urandom_range(7, 0) == 0) addr = $urandom() | 32'h0000_1000;
            else addr = 32'((64 + $urandom_range(63, 0)) * 4 + $urandom_range(3, 0));
            apply_stimulus(we, addr, wdata, be, int'($urandom_range(2, 0)), rd, er, lat);
            model_op(we, addr, wdata, be, mrd, mer);
            check_output("rand_rdata", rd, mrd);
            check_output("rand_err", 32'(er), 32'(mer));
            check_output("rand_latency", 32'(lat), 32'(LAT));
            addr = 32'((64 + $urandom_range(63, 0)) * 4);
            check_dbg("rand_dbg", addr, model[addr[11:2]]);
        end

        $display("[TB] LATENCY=0 back-to-back");
        z_we_seq[0] = 1'b1; z_addr_seq[0] = 32'h0; z_data_seq[0] = 32'hA5A5_0001; z_exp_seq[0] = 32'h0;
        z_we_seq[1] = 1'b1; z_addr_seq[1] = 32'h4; z_data_seq[1] = 32'h5A5A_0002; z_exp_seq[1] = 32'h0;
        z_we_seq[2] = 1'b0; z_addr_seq[2] = 32'h0; z_data_seq[2] = 32'h0;         z_exp_seq[2] = 32'hA5A5_0001;
        z_we_seq[3] = 1'b0; z_addr_seq[3] = 32'h4; z_data_seq[3] = 32'h0;         z_exp_seq[3] = 32'h5A5A_0002;
        for (int i = 0; i < 4; i++) begin
            acc_cyc[i] = -100; rsp_cyc[i] = -100; rsp_data[i] = 32'hX; rsp_err[i] = 1'bX;
        end
        k = 0; r = 0; accepted = 1'b0;
        z_req_valid = 1'b1; z_req_we = z_we_seq[0]; z_req_addr = z_addr_seq[0];
        z_req_wdata = z_data_seq[0]; z_req_be = 4'hF; z_resp_ready = 1'b1;
        for (int c = 0; c < 40 && r < 4; c++) begin
            if (z_resp_valid && r < 4) begin
                rsp_cyc[r] = c; rsp_data[r] = z_resp_rdata; rsp_err[r] = z_resp_err;
                r++;
            end
            if (accepted) begin
                accepted = 1'b0;
                k++;
                if (k < 4) begin
                    z_req_we = z_we_seq[k]; z_req_addr = z_addr_seq[k]; z_req_wdata = z_data_seq[k];
                end else begin
                    z_req_valid = 1'b0;
                end
            end
            if (z_req_ready && z_req_valid && k < 4) begin
                acc_cyc[k] = c;
                accepted   = 1'b1;
            end
            @(negedge clk);
        end
        z_req_valid = 1'b0;
        z_resp_ready = 1'b0;
        check_output("lat0_resp_count", 32'(r), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("lat0_resp%0d_delay", i), 32'(rsp_cyc[i] - acc_cyc[i]), 32'd1);
            check_output($sformatf("lat0_resp%0d_rdata", i), rsp_data[i], z_exp_seq[i]);
            check_output($sformatf("lat0_resp%0d_err", i), 32'(rsp_err[i]), 32'd0);
            if (i > 0) check_output($sformatf("lat0_spacing%0d", i), 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);
        end
        z_dbg_addr = 32'h4;
        #1;
        check_output("lat0_dbg", z_dbg_rdata, 32'h5A5A_0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
